// File: rtl/alerta_proximidad.sv
// Proximity alert: hysteretic distance zones, LED bar, buzzer cadence and sensor timeout.
// Optional build macro BUZZER_TONE_EN: 2 kHz square-wave buzzer instead of a steady level.
module alerta_proximidad #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int HYST_CM    = 5,
    parameter int TIMEOUT_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] dist_cm,
    input  logic       dist_valid,
    output logic       led_50cm,
    output logic       led_100cm,
    output logic       led_200cm,
    output logic       buzzer,
    output logic       sensor_fault,
    output logic [1:0] zone_dbg_o
);

    // Encoding grows with closeness, so "closer" is a plain magnitude compare.
    typedef enum logic [1:0] {
        FAR  = 2'd0,
        Z200 = 2'd1,
        Z100 = 2'd2,
        Z50  = 2'd3
    } zone_t;

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int TO_CYC = TIMEOUT_MS * MS_CYC;
    localparam int MS_W   = $clog2(MS_CYC + 1);
    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam logic [15:0] THR50  = 16'(50 + HYST_CM);
    localparam logic [15:0] THR100 = 16'(100 + HYST_CM);
    localparam logic [15:0] THR200 = 16'(200 + HYST_CM);

    zone_t            zone_q, zone_d, raw_zone;
    logic             fault_q, fault_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [9:0]       phase_q, phase_d;
    logic [2:0]       leds_q;
    logic             buzzer_q, buzzer_d;
    logic             on_d, zone_chg;
    logic [15:0]      release_thr;

    always_comb begin
        if (dist_cm < 9'd50)       raw_zone = Z50;
        else if (dist_cm < 9'd100) raw_zone = Z100;
        else if (dist_cm < 9'd200) raw_zone = Z200;
        else                       raw_zone = FAR;
    end

    always_comb begin
        case (zone_q)
            Z50:     release_thr = THR50;
            Z100:    release_thr = THR100;
            Z200:    release_thr = THR200;
            default: release_thr = 16'hFFFF;
        endcase
    end

    // Zone and timeout; a strobe always beats a simultaneous expiry.
    always_comb begin
        zone_d   = zone_q;
        fault_d  = fault_q;
        to_cnt_d = to_cnt_q;
        if (dist_valid) begin
            to_cnt_d = '0;
            fault_d  = 1'b0;
            if (fault_q || raw_zone > zone_q)
                zone_d = raw_zone;
            else if (raw_zone < zone_q && {7'd0, dist_cm} >= release_thr)
                zone_d = raw_zone;
        end else if (!fault_q) begin
            if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                fault_d = 1'b1;
                zone_d  = FAR;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign zone_chg = (zone_d != zone_q);

    // ms prescaler feeds a phase counter that wraps at the cadence period.
    always_comb begin
        ms_cnt_d = ms_cnt_q;
        phase_d  = phase_q;
        if (zone_chg) begin
            ms_cnt_d = '0;
            phase_d  = '0;
        end else if (ms_cnt_q == MS_W'(MS_CYC - 1)) begin
            ms_cnt_d = '0;
            if (phase_q == ((zone_q == Z100) ? 10'd399 : 10'd799))
                phase_d = '0;
            else
                phase_d = phase_q + 10'd1;
        end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
        end
    end

    assign on_d = (zone_d == Z50) ||
                  (((zone_d == Z100) || (zone_d == Z200)) && (phase_d < 10'd100));

`ifdef BUZZER_TONE_EN
    localparam int HALF_CYC = CLK_HZ / 4000;
    localparam int HALF_W   = $clog2(HALF_CYC + 1);

    logic [HALF_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;

    // Tone restarts high at every ON-phase start and on any zone change.
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        if (zone_chg || !on_d) begin
            tone_cnt_d = '0;
            tone_d     = 1'b1;
        end else if (tone_cnt_q == HALF_W'(HALF_CYC - 1)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
        end
        buzzer_d = on_d & tone_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b1;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end
`else
    assign buzzer_d = on_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q   <= FAR;
            fault_q  <= 1'b0;
            to_cnt_q <= '0;
            ms_cnt_q <= '0;
            phase_q  <= '0;
            leds_q   <= 3'b000;
            buzzer_q <= 1'b0;
        end else begin
            zone_q   <= zone_d;
            fault_q  <= fault_d;
            to_cnt_q <= to_cnt_d;
            ms_cnt_q <= ms_cnt_d;
            phase_q  <= phase_d;
            leds_q   <= {zone_d == Z50, zone_d == Z100, zone_d == Z200};
            buzzer_q <= buzzer_d;
        end
    end

    assign led_50cm     = leds_q[2];
    assign led_100cm    = leds_q[1];
    assign led_200cm    = leds_q[0];
    assign buzzer       = buzzer_q;
    assign sensor_fault = fault_q;
    assign zone_dbg_o   = zone_q;

endmodule

// File: tb/tb_alerta_proximidad.sv
// Bench for alerta_proximidad: directed scenarios plus random strobes, checked every cycle
// against a timeline model of zones, cadence and timeout.
module tb_alerta_proximidad;

    // Slow clock keeps whole cadence periods and timeouts short in cycles.
    localparam int CLK_HZ     = 8000;
    localparam int HYST_CM    = 5;
    localparam int TIMEOUT_MS = 100;
    localparam int MS         = CLK_HZ / 1000;
    localparam int TO_CYC     = TIMEOUT_MS * MS;
    localparam int HALF       = CLK_HZ / 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dist_valid = 1'b0;
    logic [8:0] dist_cm = '0;
    logic       led_50cm, led_100cm, led_200cm, buzzer, sensor_fault;
    logic [1:0] zone_dbg;

    always #5 clk = ~clk;

    alerta_proximidad #(
        .CLK_HZ(CLK_HZ),
        .HYST_CM(HYST_CM),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dist_cm(dist_cm),
        .dist_valid(dist_valid),
        .led_50cm(led_50cm),
        .led_100cm(led_100cm),
        .led_200cm(led_200cm),
        .buzzer(buzzer),
        .sensor_fault(sensor_fault),
        .zone_dbg_o(zone_dbg)
    );

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    string      scen = "reset";

    // Model: closeness 0=FAR..3=Z50, cycles since zone change, idle cycles since last strobe.
    int m_zone = 0;
    int m_t    = 0;
    int m_idle = 0;
    bit m_fault = 1'b0;

    function automatic int raw_of(input int d);
        if (d < 50)  return 3;
        if (d < 100) return 2;
        if (d < 200) return 1;
        return 0;
    endfunction

    function automatic int upper_of(input int z);
        if (z == 3) return 50;
        if (z == 2) return 100;
        return 200;
    endfunction

    function automatic logic [4:0] model_out();
        bit on;
        int ph;
        on = 1'b0;
        ph = 0;
        if (m_zone == 3) begin
            on = 1'b1;
            ph = m_t;
        end else if (m_zone == 2) begin
            ph = m_t % (400 * MS);
            on = (ph < 100 * MS);
        end else if (m_zone == 1) begin
            ph = m_t % (800 * MS);
            on = (ph < 100 * MS);
        end
`ifdef BUZZER_TONE_EN
        on = on && (((ph / HALF) % 2) == 0);
`endif
        return {m_zone == 3, m_zone == 2, m_zone == 1, on, m_fault};
    endfunction

    task automatic model_step(input bit r, input bit v, input int d);
        int nz;
        int rz;
        if (r) begin
            m_zone = 0; m_fault = 1'b0; m_idle = 0; m_t = 0;
        end else begin
            nz = m_zone;
            if (v) begin
                m_idle = 0;
                rz = raw_of(d);
                if (m_fault || rz > m_zone) nz = rz;
                else if (rz < m_zone && d >= upper_of(m_zone) + HYST_CM) nz = rz;
                m_fault = 1'b0;
            end else if (!m_fault) begin
                m_idle++;
                if (m_idle >= TO_CYC) begin
                    m_fault = 1'b1;
                    nz = 0;
                end
            end
            if (nz != m_zone) m_t = 0;
            else m_t++;
            m_zone = nz;
        end
    endtask

    task automatic step(input bit r, input bit v, input int d);
        @(negedge clk);
        rst = r;
        dist_valid = v;
        dist_cm = 9'(d);
        @(posedge clk);
        model_step(r, v, d);
        exp_q.push_back(model_out());
    endtask

    task automatic strobe(input int d);
        step(1'b0, 1'b1, d);
    endtask

    // dist_cm wanders while dist_valid is low; it must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, 511)));
    endtask

    function automatic int rand_dist();
        int edges[14] = '{0, 49, 50, 54, 55, 99, 100, 104, 105, 199, 200, 204, 205, 511};
        if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 13)];
        return int'($urandom_range(0, 511));
    endfunction

    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {led_50cm, led_100cm, led_200cm, buzzer, sensor_fault};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s t=%0t led50/100/200/buz/fault got %b expected %b",
                             scen, $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 30);
        idle(3);

        scen = "near";
        strobe(30);
        idle(40);

        scen = "cadence";
        for (int k = 0; k < 20; k++) begin
            strobe(75);
            idle(50 * MS - 1);
        end

        scen = "hysteresis";
        strobe(102); idle(5);
        strobe(105); idle(5);
        strobe(99);  idle(5);
        strobe(52);  idle(5);
        strobe(40);  idle(5);
        strobe(54);  idle(5);
        strobe(55);  idle(5);

        scen = "jump";
        strobe(150); idle(5);
        strobe(20);  idle(5);
        strobe(260); idle(5);

        scen = "timeout";
        strobe(150);
        idle(TO_CYC + 20);
        strobe(60);
        idle(20);

        scen = "expiry_race";
        strobe(150);
        idle(TO_CYC - 1);
        strobe(30);
        idle(20);

        scen = "reset";
        strobe(30);
        idle(30);
        step(1'b1, 1'b1, 150);
        idle(TO_CYC + 10);

        scen = "random";
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 14) == 0) step(1'b1, $urandom_range(0, 1) == 1, rand_dist());
            else strobe(rand_dist());
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(TO_CYC - 2, TO_CYC + 2)));
            else idle(int'($urandom_range(0, 400)));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
